fetch_unit: RTL

//  Instruction fetch stage directly upstream of the decoder. Holds the PC, issues

---
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Latency: request accept -> instr_valid is memory response latency + 1 cycle (no bypass).
// Backpressure: decoder stalls fill the buffer. Requests are credit-limited so that
//   buffered + outstanding <= FIFO_DEPTH, so a response always has a free slot.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       word request to instruction memory (addr = pc)
//   imem_rsp_valid/data             in-order response words, no backpressure
//   redirect_valid/pc               taken branch / jump: flush and restart fetch
//   instr_valid/ready, instr, instr_pc  buffer head presented to decode
//   fetch_fault                     sticky misaligned-redirect fault
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When it is defined, a redirect to a
// non-word-aligned target raises fetch_fault, which is sticky until reset and stops
// all further fetching. When it is not defined, redirect_pc[1:0] is ignored and
// fetch_fault is tied low.

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] DEPTH_SUM = SW'(FIFO_DEPTH);

  // fetch state
  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  // instruction buffer
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [31:0]   redirect_tgt;
  logic [SW-1:0] credit_used;
  logic          accept;
  logic          dropping;
  logic          push;
  logic          pop;

  // Targets are always forced to a word boundary; with the alignment check enabled a
  // misaligned target faults anyway, so what it would have fetched does not matter.
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end

  assign fetch_fault = fault_q;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign fetch_fault     = 1'b0;
`endif

  // Credit check: every outstanding request owns a buffer slot, so the buffer can
  // never overflow regardless of decoder stalls.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  // rst_n gating keeps the request low while reset is held yet allows a request in
  // the very first cycle after release.
  assign imem_req_valid = rst_n && !redirect_valid && !fetch_fault && (credit_used < DEPTH_SUM);
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Responses to requests issued before the latest redirect are discarded.
  assign dropping = (drop_cnt != '0);
  assign push     = imem_rsp_valid && !dropping && !redirect_valid;

  assign instr_valid = (count != '0);
  assign instr       = data_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];
  // A handshake in a redirect cycle is squashed along with the rest of the buffer.
  assign pop         = instr_valid && instr_ready && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect_valid) begin
      // No request is issued in a redirect cycle; a response arriving now is dropped
      // here, every other in-flight response is dropped later via drop_cnt.
      pc          <= redirect_tgt;
      resp_pc     <= redirect_tgt;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop_cnt    <= outstanding - CW'(imem_rsp_valid);
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (accept) begin
        pc <= pc + 32'd4;
      end
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && dropping) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Buffer storage needs no reset: contents are only visible when count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == DEPTH_CNT)));

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (outstanding == '0)));

  a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (outstanding <= DEPTH_CNT) && (drop_cnt <= DEPTH_CNT));

endmodule
